// File: rtl/viti_mc_capture.sv
// Multi-channel VITI capture controller: captures DEPTH samples from NCH TDL channels,
// frames them out over a byte-wide UART handshake and tracks per-channel popcount calibration.
module viti_mc_capture #(
  parameter int NCH      = 2,
  parameter int SAMPLE_W = 4,
  parameter int DEPTH    = 256,
  parameter int WIN_LO   = 145,
  parameter int WIN_HI   = 176,
  parameter int REF_INIT = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             trig,
  input  logic                             sample_valid,
  input  logic [NCH*SAMPLE_W-1:0]          sample_data,
  input  logic                             uart_tx_Active,
  input  logic                             uart_tx_Done,
  output logic                             uart_tx_DV,
  output logic [7:0]                       uart_tx_Byte,
  output logic                             busy,
  output logic                             frame_done,
  output logic [NCH-1:0]                   calib_lock,
  output logic [NCH*$clog2(SAMPLE_W+1)-1:0] ref_ones
);
  localparam int AW      = $clog2(DEPTH);
  localparam int WIN_LEN = WIN_HI - WIN_LO + 1;
  localparam int MW      = $clog2(WIN_LEN + 1);
  localparam int RW      = $clog2(SAMPLE_W + 1);
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [7:0] NCH_BYTE = 8'(NCH);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_HDR, S_LOAD, S_SEND, S_WAIT, S_EVAL} state_t;

  function automatic logic [RW-1:0] popcount(input logic [SAMPLE_W-1:0] v);
    logic [RW-1:0] n;
    n = '0;
    for (int i = 0; i < SAMPLE_W; i++) n = n + RW'(v[i]);
    return n;
  endfunction

  state_t                      state;
  logic [NCH*SAMPLE_W-1:0]     mem [DEPTH];
  logic [NCH*SAMPLE_W-1:0]     rd_p1;
  logic [AW-1:0]               wr_idx;
  logic [AW-1:0]               rd_idx;
  logic [CW-1:0]               ch;
  logic                        in_hdr;
  logic                        hdr_sel;
  logic                        ld_ph;
  logic [MW-1:0]               mismatch [NCH];
  logic [RW-1:0]               ref_r [NCH];
  logic [SAMPLE_W-1:0]         cur_smp;
  logic [RW-1:0]               cur_pop;
  logic                        in_win;

  always_comb begin
    cur_smp = rd_p1[int'(ch)*SAMPLE_W +: SAMPLE_W];
    cur_pop = popcount(cur_smp);
    in_win  = (int'(rd_idx) >= WIN_LO) && (int'(rd_idx) <= WIN_HI);
  end

  // Sample buffer: written only in FILL, read with one cycle of latency.
  always_ff @(posedge clk) begin
    if (state == S_FILL && sample_valid) mem[wr_idx] <= sample_data;
    rd_p1 <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      uart_tx_DV   <= 1'b0;
      uart_tx_Byte <= 8'h00;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      calib_lock   <= '0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      ch           <= '0;
      in_hdr       <= 1'b0;
      hdr_sel      <= 1'b0;
      ld_ph        <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        mismatch[c] <= '0;
        ref_r[c]    <= RW'(REF_INIT);
      end
    end else begin
      uart_tx_DV <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: if (trig) begin
          busy   <= 1'b1;
          wr_idx <= '0;
          for (int c = 0; c < NCH; c++) mismatch[c] <= '0;
          state  <= S_FILL;
        end
        S_FILL: if (sample_valid) begin
          wr_idx <= wr_idx + AW'(1);
          if (wr_idx == AW'(DEPTH - 1)) begin
            in_hdr  <= 1'b1;
            hdr_sel <= 1'b0;
            state   <= S_HDR;
          end
        end
        S_HDR: begin
          uart_tx_Byte <= hdr_sel ? NCH_BYTE : 8'hA5;
          state        <= S_SEND;
        end
        // First LOAD cycle lets rd_p1 catch up with rd_idx; the second consumes it.
        S_LOAD: begin
          if (!ld_ph) begin
            ld_ph <= 1'b1;
          end else begin
            ld_ph        <= 1'b0;
            uart_tx_Byte <= 8'(cur_smp);
            if (in_win && cur_pop != ref_r[ch]) mismatch[ch] <= mismatch[ch] + MW'(1);
            state        <= S_SEND;
          end
        end
        S_SEND: if (!uart_tx_Active) begin
          uart_tx_DV <= 1'b1;
          state      <= S_WAIT;
        end
        S_WAIT: if (uart_tx_Done) begin
          if (in_hdr) begin
            if (hdr_sel) begin
              in_hdr <= 1'b0;
              rd_idx <= '0;
              ch     <= '0;
              ld_ph  <= 1'b0;
              state  <= S_LOAD;
            end else begin
              hdr_sel <= 1'b1;
              state   <= S_HDR;
            end
          end else if (rd_idx == AW'(DEPTH - 1) && ch == CW'(NCH - 1)) begin
            state <= S_EVAL;
          end else begin
            if (ch == CW'(NCH - 1)) begin
              ch     <= '0;
              rd_idx <= rd_idx + AW'(1);
            end else begin
              ch <= ch + CW'(1);
            end
            ld_ph <= 1'b0;
            state <= S_LOAD;
          end
        end
        // rd_p1 still holds the last sample of the buffer here.
        S_EVAL: begin
          for (int c = 0; c < NCH; c++) begin
            if (mismatch[c] == MW'(WIN_LEN))
              ref_r[c] <= popcount(rd_p1[c*SAMPLE_W +: SAMPLE_W]);
            else if (mismatch[c] != '0)
              calib_lock[c] <= 1'b1;
          end
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ref
    assign ref_ones[g*RW +: RW] = ref_r[g];
  end
endmodule
